pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the RISC-V core. It replaces the bare combinational PC+4 adder with a registered PC and prioritised next-PC selection (sequential, branch/JAL, JALR, trap), stall and halt control, misaligned-target trapping, and a retired-instruction counter. It sits at the head of the fetch path: `pc_o` drives instruction memory, and `pc_plus_inc_o` feeds the link-register writeback mux.

## Interface
- `XLEN`, 32: PC/target width.
- `INC`, 4: sequential increment in bytes (4 = RV32I, no C extension).
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `CNT_W`, 64: width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hold PC and state this cycle.
- `halt_i`  in  1  enter HALT (ECALL/EBREAK decode).
- `resume_i`  in  1  leave HALT.
- `br_taken_i`  in  1  branch/JAL redirect.
- `br_target_i`  in  XLEN  branch/JAL target.
- `jalr_i`  in  1  JALR redirect.
- `jalr_target_i`  in  XLEN  raw rs1+imm.
- `trap_i`  in  1  external trap request.
- `trap_vec_i`  in  XLEN  trap handler address (mtvec).
- `pc_o`  out  XLEN  current PC.
- `pc_plus_inc_o`  out  XLEN  `pc_o + INC`, combinational.
- `epc_o`  out  XLEN  PC of the last trapping instruction.
- `cause_o`  out  4  last trap cause.
- `misalign_o`  out  1  one-cycle pulse when a misaligned redirect is caught.
- `halted_o`  out  1  high in HALT.
- `instret_o`  out  CNT_W  count of PC advances in RUN.

## Operation
- States: RESET, RUN, HALT.
- RESET is entered asynchronously while `rst_n`=0. On the first clock after release, the block moves to RUN; no PC update happens on that edge.
- Next-PC in RUN, in priority order, highest first:
  1. `trap_i`: PC←`trap_vec_i`, epc←PC, cause←4'd11.
  2. Misaligned redirect: PC←`trap_vec_i`, epc←PC, cause←4'd0, `misalign_o`=1.
  3. `jalr_i`: PC←`{jalr_target_i[XLEN-1:1],1'b0}`.
  4. `br_taken_i`: PC←`br_target_i`.
  5. Otherwise: PC←PC+INC.
- Misaligned means the effective target has `[1:0]`≠0 when INC=4, or `[0]`≠0 when INC=2. For JALR, the check applies after bit 0 is cleared.
- `jalr_i` and `br_taken_i` both high: JALR wins.
- `stall_i`=1: PC, state, epc, cause and counter all hold. Trap and redirect inputs are ignored that cycle, and the decoder must hold them until the stall clears.
- `halt_i` in RUN with no stall: PC←PC+INC, then enter HALT.
- HALT: PC frozen. `resume_i` returns to RUN. `trap_i` in HALT takes the trap and returns to RUN.
- Arithmetic is modulo 2^XLEN. `XLEN'hFFFF_FFFC`+4 → 0, with no flag.
- `instret_o` increments by 1 on every RUN edge where PC is updated and `stall_i`=0, including redirects and traps. It wraps silently.

## Timing
- Reset values: `pc_o`=RESET_VECTOR, `epc_o`=0, `cause_o`=0, `misalign_o`=0, `halted_o`=0, `instret_o`=0, state=RESET.
- Next-PC latency is one cycle: inputs sampled at edge N appear on `pc_o` after edge N.
- `pc_plus_inc_o` has zero latency relative to `pc_o`.
- `misalign_o` is registered: high for exactly the one cycle after the trapping edge.
- Reset asserted mid-operation clears everything immediately, with no clock needed. The first fetch after reset is RESET_VECTOR, presented for 2 cycles because of the RESET state.

## Structure
- Shared package `pc_seq_pkg`:
  - state enum `pc_state_e` {RESET, RUN, HALT};
  - cause constants `CAUSE_IADDR_MISALIGN`=4'd0 and `CAUSE_ECALL_M`=4'd11.
- One natural sub-module, `pc_next_mux`: purely combinational priority select plus misalignment check. The top holds the FSM and registers.

## Test plan
- Reset release, no redirects, 4 cycles → `pc_o` sequence 0, 0, 4, 8, 12; `instret_o`=3.
- PC=`FFFF_FFF8`, run 2 cycles → `FFFF_FFFC`, then `0000_0000`; `misalign_o` stays 0.
- PC=0x100, `br_taken_i` with target 0x202 → `pc_o`=`trap_vec_i` (0x80), `epc_o`=0x100, `cause_o`=0, `misalign_o` pulses once.
- PC=0x40, `jalr_i` with target 0x301 plus `br_taken_i` with target 0x500 → `pc_o`=0x300.
- PC=0x20, `stall_i` high for 3 cycles with `br_taken_i` asserted → `pc_o` stays 0x20 and `instret_o` unchanged; after the stall clears, `pc_o`=target.
- `halt_i` at PC=0x10 → `pc_o`=0x14 and `halted_o`=1 for 5 cycles; `resume_i` → 0x18. Then `rst_n` pulled low mid-cycle → `pc_o`=0 immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RESET,
    RUN,
    HALT
  } pc_state_e;

  localparam logic [3:0] CAUSE_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select: trap, misaligned redirect, JALR, branch, sequential.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int INC  = 4
) (
  input  logic [XLEN-1:0] pcPlusInc,
  input  logic            brTaken,
  input  logic [XLEN-1:0] brTarget,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalrTarget,
  input  logic            trap,
  input  logic [XLEN-1:0] trapVec,
  output logic [XLEN-1:0] nextPc,
  output logic            trapTaken,
  output logic            misalign,
  output logic [3:0]      trapCause
);

  // Low address bits that must be zero for a legal fetch target.
  localparam logic [XLEN-1:0] ALIGN_MASK = (INC == 4) ? XLEN'(3) :
                                           (INC == 2) ? XLEN'(1) : '0;

  logic [XLEN-1:0] redirTarget;
  logic            redirect;
  logic            redirMisaligned;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    redirTarget = brTarget;
    if (jalr) redirTarget = {jalrTarget[XLEN-1:1], 1'b0};
  end

  assign redirect        = jalr | brTaken;
  assign redirMisaligned = redirect && ((redirTarget & ALIGN_MASK) != '0);

  always_comb begin
    nextPc    = pcPlusInc;
    trapTaken = 1'b0;
    misalign  = 1'b0;
    trapCause = CAUSE_ECALL_M;
    if (trap) begin
      nextPc    = trapVec;
      trapTaken = 1'b1;
    end else if (redirMisaligned) begin
      nextPc    = trapVec;
      trapTaken = 1'b1;
      misalign  = 1'b1;
      trapCause = CAUSE_IADDR_MISALIGN;
    end else if (redirect) begin
      nextPc = redirTarget;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with RESET/RUN/HALT control, trap capture and retired-instruction count.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic             jalr_i,
  input  logic [XLEN-1:0]  jalr_target_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus_inc_o,
  output logic [XLEN-1:0]  epc_o,
  output logic [3:0]       cause_o,
  output logic             misalign_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instret_o
);

  pc_state_e       state;
  logic [XLEN-1:0] nextPc;
  logic            trapTaken;
  logic            misalign;
  logic [3:0]      trapCause;

  assign pc_plus_inc_o = pc_o + XLEN'(INC);

  pc_next_mux #(
    .XLEN(XLEN),
    .INC (INC)
  ) u_next_mux (
    .pcPlusInc (pc_plus_inc_o),
    .brTaken   (br_taken_i),
    .brTarget  (br_target_i),
    .jalr      (jalr_i),
    .jalrTarget(jalr_target_i),
    .trap      (trap_i),
    .trapVec   (trap_vec_i),
    .nextPc    (nextPc),
    .trapTaken (trapTaken),
    .misalign  (misalign),
    .trapCause (trapCause)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET;
      pc_o       <= RESET_VECTOR;
      epc_o      <= '0;
      cause_o    <= '0;
      misalign_o <= 1'b0;
      halted_o   <= 1'b0;
      instret_o  <= '0;
    end else begin
      misalign_o <= 1'b0;
      if (!stall_i) begin
        case (state)
          RESET: state <= RUN;
          RUN: begin
            instret_o <= instret_o + CNT_W'(1);
            if (trapTaken) begin
              pc_o       <= nextPc;
              epc_o      <= pc_o;
              cause_o    <= trapCause;
              misalign_o <= misalign;
            end else if (halt_i) begin
              // The halting instruction itself retires, so the PC still advances.
              pc_o     <= pc_plus_inc_o;
              state    <= HALT;
              halted_o <= 1'b1;
            end else begin
              pc_o <= nextPc;
            end
          end
          HALT: begin
            if (trap_i) begin
              pc_o     <= trap_vec_i;
              epc_o    <= pc_o;
              cause_o  <= CAUSE_ECALL_M;
              state    <= RUN;
              halted_o <= 1'b0;
            end else if (resume_i) begin
              state    <= RUN;
              halted_o <= 1'b0;
            end
          end
          default: state <= RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; each task checks one feature inline.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, halt_i, resume_i;
  logic        br_taken_i, jalr_i, trap_i;
  logic [31:0] br_target_i, jalr_target_i, trap_vec_i;
  logic [31:0] pc_o, pc_plus_inc_o, epc_o;
  logic [3:0]  cause_o;
  logic        misalign_o, halted_o;
  logic [63:0] instret_o;

  int checks = 0;
  int passes = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .halt_i       (halt_i),
    .resume_i     (resume_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jalr_i       (jalr_i),
    .jalr_target_i(jalr_target_i),
    .trap_i       (trap_i),
    .trap_vec_i   (trap_vec_i),
    .pc_o         (pc_o),
    .pc_plus_inc_o(pc_plus_inc_o),
    .epc_o        (epc_o),
    .cause_o      (cause_o),
    .misalign_o   (misalign_o),
    .halted_o     (halted_o),
    .instret_o    (instret_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic jump_to(input logic [31:0] addr);
    br_taken_i  = 1'b1;
    br_target_i = addr;
    step();
    br_taken_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0) $display("FAIL rst_pc: got %h expected %h", pc_o, 32'h0); else passes++;
    checks++; if (epc_o !== 32'h0) $display("FAIL rst_epc: got %h expected %h", epc_o, 32'h0); else passes++;
    checks++; if (cause_o !== 4'd0) $display("FAIL rst_cause: got %0d expected 0", cause_o); else passes++;
    checks++; if (misalign_o !== 1'b0) $display("FAIL rst_misalign: got %b expected 0", misalign_o); else passes++;
    checks++; if (halted_o !== 1'b0) $display("FAIL rst_halted: got %b expected 0", halted_o); else passes++;
    checks++; if (instret_o !== 64'd0) $display("FAIL rst_instret: got %0d expected 0", instret_o); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (pc_o !== 32'h0) $display("FAIL seq_pc0: got %h expected %h", pc_o, 32'h0); else passes++;
    step();
    checks++; if (pc_o !== 32'h0) $display("FAIL seq_pc1: got %h expected %h", pc_o, 32'h0); else passes++;
    step();
    checks++; if (pc_o !== 32'h4) $display("FAIL seq_pc2: got %h expected %h", pc_o, 32'h4); else passes++;
    step();
    checks++; if (pc_o !== 32'h8) $display("FAIL seq_pc3: got %h expected %h", pc_o, 32'h8); else passes++;
    step();
    checks++; if (pc_o !== 32'hC) $display("FAIL seq_pc4: got %h expected %h", pc_o, 32'hC); else passes++;
    checks++; if (pc_plus_inc_o !== 32'h10) $display("FAIL seq_pc_plus: got %h expected %h", pc_plus_inc_o, 32'h10); else passes++;
    checks++; if (instret_o !== 64'd3) $display("FAIL seq_instret: got %0d expected 3", instret_o); else passes++;
  endtask

  task automatic test_wrap();
    reset_dut();
    jump_to(32'hFFFF_FFF8);
    checks++; if (pc_o !== 32'hFFFF_FFF8) $display("FAIL wrap_start: got %h expected %h", pc_o, 32'hFFFF_FFF8); else passes++;
    step();
    checks++; if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1: got %h expected %h", pc_o, 32'hFFFF_FFFC); else passes++;
    checks++; if (pc_plus_inc_o !== 32'h0) $display("FAIL wrap_plus: got %h expected %h", pc_plus_inc_o, 32'h0); else passes++;
    step();
    checks++; if (pc_o !== 32'h0) $display("FAIL wrap_pc2: got %h expected %h", pc_o, 32'h0); else passes++;
    checks++; if (misalign_o !== 1'b0) $display("FAIL wrap_misalign: got %b expected 0", misalign_o); else passes++;
  endtask

  task automatic test_misalign();
    reset_dut();
    jump_to(32'h100);
    br_taken_i  = 1'b1;
    br_target_i = 32'h202;
    step();
    br_taken_i  = 1'b0;
    checks++; if (pc_o !== 32'h80) $display("FAIL mis_pc: got %h expected %h", pc_o, 32'h80); else passes++;
    checks++; if (epc_o !== 32'h100) $display("FAIL mis_epc: got %h expected %h", epc_o, 32'h100); else passes++;
    checks++; if (cause_o !== 4'd0) $display("FAIL mis_cause: got %0d expected 0", cause_o); else passes++;
    checks++; if (misalign_o !== 1'b1) $display("FAIL mis_pulse: got %b expected 1", misalign_o); else passes++;
    checks++; if (instret_o !== 64'd2) $display("FAIL mis_instret: got %0d expected 2", instret_o); else passes++;
    step();
    checks++; if (misalign_o !== 1'b0) $display("FAIL mis_pulse_end: got %b expected 0", misalign_o); else passes++;
    checks++; if (pc_o !== 32'h84) $display("FAIL mis_after: got %h expected %h", pc_o, 32'h84); else passes++;
  endtask

  task automatic test_jalr_priority();
    reset_dut();
    jump_to(32'h40);
    jalr_i        = 1'b1;
    jalr_target_i = 32'h301;
    br_taken_i    = 1'b1;
    br_target_i   = 32'h500;
    step();
    jalr_i     = 1'b0;
    br_taken_i = 1'b0;
    checks++; if (pc_o !== 32'h300) $display("FAIL jalr_pc: got %h expected %h", pc_o, 32'h300); else passes++;
    checks++; if (misalign_o !== 1'b0) $display("FAIL jalr_misalign: got %b expected 0", misalign_o); else passes++;
    // JALR target with bit 1 set stays misaligned after bit 0 is cleared.
    jalr_i        = 1'b1;
    jalr_target_i = 32'h403;
    step();
    jalr_i = 1'b0;
    checks++; if (pc_o !== 32'h80) $display("FAIL jalr_mis_pc: got %h expected %h", pc_o, 32'h80); else passes++;
    checks++; if (epc_o !== 32'h300) $display("FAIL jalr_mis_epc: got %h expected %h", epc_o, 32'h300); else passes++;
  endtask

  task automatic test_stall();
    reset_dut();
    jump_to(32'h20);
    stall_i     = 1'b1;
    br_taken_i  = 1'b1;
    br_target_i = 32'h60;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_o !== 32'h20) $display("FAIL stall_pc%0d: got %h expected %h", i, pc_o, 32'h20); else passes++;
      checks++; if (instret_o !== 64'd1) $display("FAIL stall_instret%0d: got %0d expected 1", i, instret_o); else passes++;
    end
    stall_i = 1'b0;
    step();
    br_taken_i = 1'b0;
    checks++; if (pc_o !== 32'h60) $display("FAIL stall_release: got %h expected %h", pc_o, 32'h60); else passes++;
    checks++; if (instret_o !== 64'd2) $display("FAIL stall_instret_end: got %0d expected 2", instret_o); else passes++;
  endtask

  task automatic test_trap();
    reset_dut();
    jump_to(32'h200);
    trap_i      = 1'b1;
    br_taken_i  = 1'b1;
    br_target_i = 32'h700;
    step();
    trap_i     = 1'b0;
    br_taken_i = 1'b0;
    checks++; if (pc_o !== 32'h80) $display("FAIL trap_pc: got %h expected %h", pc_o, 32'h80); else passes++;
    checks++; if (epc_o !== 32'h200) $display("FAIL trap_epc: got %h expected %h", epc_o, 32'h200); else passes++;
    checks++; if (cause_o !== 4'd11) $display("FAIL trap_cause: got %0d expected 11", cause_o); else passes++;
    checks++; if (misalign_o !== 1'b0) $display("FAIL trap_misalign: got %b expected 0", misalign_o); else passes++;
    checks++; if (instret_o !== 64'd2) $display("FAIL trap_instret: got %0d expected 2", instret_o); else passes++;
  endtask

  task automatic test_halt();
    reset_dut();
    jump_to(32'h10);
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (pc_o !== 32'h14) $display("FAIL halt_pc%0d: got %h expected %h", i, pc_o, 32'h14); else passes++;
      checks++; if (halted_o !== 1'b1) $display("FAIL halt_flag%0d: got %b expected 1", i, halted_o); else passes++;
      if (i < 4) step();
    end
    checks++; if (instret_o !== 64'd2) $display("FAIL halt_instret: got %0d expected 2", instret_o); else passes++;
    resume_i = 1'b1;
    step();
    resume_i = 1'b0;
    checks++; if (halted_o !== 1'b0) $display("FAIL resume_flag: got %b expected 0", halted_o); else passes++;
    step();
    checks++; if (pc_o !== 32'h18) $display("FAIL resume_pc: got %h expected %h", pc_o, 32'h18); else passes++;
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    trap_i = 1'b1;
    step();
    trap_i = 1'b0;
    checks++; if (pc_o !== 32'h80) $display("FAIL halt_trap_pc: got %h expected %h", pc_o, 32'h80); else passes++;
    checks++; if (epc_o !== 32'h1C) $display("FAIL halt_trap_epc: got %h expected %h", epc_o, 32'h1C); else passes++;
    checks++; if (cause_o !== 4'd11) $display("FAIL halt_trap_cause: got %0d expected 11", cause_o); else passes++;
    checks++; if (halted_o !== 1'b0) $display("FAIL halt_trap_flag: got %b expected 0", halted_o); else passes++;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0) $display("FAIL async_rst_pc: got %h expected %h", pc_o, 32'h0); else passes++;
    checks++; if (epc_o !== 32'h0) $display("FAIL async_rst_epc: got %h expected %h", epc_o, 32'h0); else passes++;
    checks++; if (instret_o !== 64'd0) $display("FAIL async_rst_instret: got %0d expected 0", instret_o); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (pc_o !== 32'h0) $display("FAIL post_rst_pc: got %h expected %h", pc_o, 32'h0); else passes++;
  endtask

  initial begin
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    halt_i        = 1'b0;
    resume_i      = 1'b0;
    br_taken_i    = 1'b0;
    br_target_i   = '0;
    jalr_i        = 1'b0;
    jalr_target_i = '0;
    trap_i        = 1'b0;
    trap_vec_i    = 32'h80;
    test_reset();
    test_wrap();
    test_misalign();
    test_jalr_priority();
    test_stall();
    test_trap();
    test_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
